// File: rtl/p405s_zero_one_predict_pipe_pkg.sv
// p405s_zopPkg: shared configuration constants and helpers for the
// zero/one predict pipeline.
//   ZOP_WIDTH_A/B : the two legal operand widths
//   ZOP_STAGES    : pipeline depth (valid shift register length)
//   numSeg()      : number of SEG_W segments in a WIDTH operand
//   cfgLegal()    : WIDTH/SEG_W legality check used at elaboration
package p405s_zopPkg;

  localparam int ZOP_WIDTH_A = 32;
  localparam int ZOP_WIDTH_B = 64;
  localparam int ZOP_STAGES  = 2;

  function automatic int numSeg(input int width, input int segW);
    return width / segW;
  endfunction

  function automatic bit cfgLegal(input int width, input int segW);
    return ((width == ZOP_WIDTH_A) || (width == ZOP_WIDTH_B)) &&
           (segW > 0) && ((width % segW) == 0);
  endfunction

endpackage

// File: rtl/p405s_zero_one_predict_pipe_bitgen.sv
// p405s_zopBitGen: per-bit zero/one predict vectors for A + B + cIn.
// Bit 0 is the MSB; each bit looks at its less significant neighbour
// (i+1) to predict the carry it would receive if everything below it
// summed to all-zeros (zp) or all-ones (op).
//   a, b  : operands (b already conditioned for subtract)
//   cIn   : carry into the LSB
//   zp/op : per-bit zero / one predict
module p405s_zopBitGen #(
  parameter int WIDTH = 32
) (
  input  logic [0:WIDTH-1] a,
  input  logic [0:WIDTH-1] b,
  input  logic             cIn,
  output logic [0:WIDTH-1] zp,
  output logic [0:WIDTH-1] op
);

  for (genvar i = 0; i < WIDTH-1; i++) begin : gBit
    assign zp[i] = ~(a[i] ^ b[i]) ^ (a[i+1] | b[i+1]);
    assign op[i] =  (a[i] ^ b[i]) ^ (a[i+1] & b[i+1]);
  end

  // LSB: the only incoming carry is cIn itself.
  assign zp[WIDTH-1] = ~(a[WIDTH-1] ^ b[WIDTH-1]) ^ cIn;
  assign op[WIDTH-1] =  (a[WIDTH-1] ^ b[WIDTH-1]) ^ cIn;

endmodule

// File: rtl/p405s_zero_one_predict_pipe.sv
// p405s_zero_one_predict_pipe: two-stage valid/ready pipeline predicting
// whether A + B + cIn (or A + ~B + cIn) is all zeros or all ones.
//   Stage 1 registers the per-bit zp/op vectors; stage 2 registers the
//   full-width and per-segment AND reductions.
// Ports:
//   CB, resetN          : clock, synchronous active-low reset
//   aIn, bIn, cIn       : operands (bit 0 = MSB) and carry-in
//   subMode             : 1 = predict A + ~B + cIn
//   inValid / inReady   : input handshake
//   outValid / outReady : output handshake
//   N_ZP, N_OP          : low = sum all zeros / all ones
//   zpSeg, opSeg        : per-segment predicts, segment 0 = MSB end
// Build option P405S_ZOP_STICKY_EN adds stickyClr, stickyZP, stickyOP:
//   sticky flags that record any delivered all-zero / all-one result.
module p405s_zero_one_predict_pipe
  import p405s_zopPkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int SEG_W   = 16,
  localparam int NUM_SEG = numSeg(WIDTH, SEG_W)
) (
  input  logic               CB,
  input  logic               resetN,
  input  logic [0:WIDTH-1]   aIn,
  input  logic [0:WIDTH-1]   bIn,
  input  logic               cIn,
  input  logic               subMode,
  input  logic               inValid,
  output logic               inReady,
  output logic               outValid,
  input  logic               outReady,
  output logic               N_ZP,
  output logic               N_OP,
  output logic [0:NUM_SEG-1] zpSeg,
  output logic [0:NUM_SEG-1] opSeg
`ifdef P405S_ZOP_STICKY_EN
  ,
  input  logic               stickyClr,
  output logic               stickyZP,
  output logic               stickyOP
`endif
);

  if (!cfgLegal(WIDTH, SEG_W)) begin : gBadCfg
    $error("p405s_zero_one_predict_pipe: illegal WIDTH/SEG_W");
  end

  logic [0:WIDTH-1]     effB, zpD, opD, s1Zp, s1Op;
  logic [0:NUM_SEG-1]   zpSegD, opSegD;
  logic [ZOP_STAGES:1]  vldPipe;   // [1] = stage 1 valid, [2] = outValid
  logic                 s1Advance, inFire;

  assign effB = subMode ? ~bIn : bIn;

  p405s_zopBitGen #(.WIDTH(WIDTH)) uBitGen (
    .a   (aIn),
    .b   (effB),
    .cIn (cIn),
    .zp  (zpD),
    .op  (opD)
  );

  for (genvar k = 0; k < NUM_SEG; k++) begin : gSeg
    assign zpSegD[k] = &s1Zp[k*SEG_W +: SEG_W];
    assign opSegD[k] = &s1Op[k*SEG_W +: SEG_W];
  end

  assign outValid  = vldPipe[2];
  assign s1Advance = ~vldPipe[2] | outReady;
  // Gated by resetN so nothing is taken while the pipe is being flushed.
  assign inReady   = resetN & (~vldPipe[1] | s1Advance);
  assign inFire    = inValid & inReady;

  always_ff @(posedge CB) begin
    if (!resetN) begin
      vldPipe <= '0;
      s1Zp    <= '0;
      s1Op    <= '0;
      N_ZP    <= 1'b1;
      N_OP    <= 1'b1;
      zpSeg   <= '0;
      opSeg   <= '0;
    end else begin
      if (inReady) vldPipe[1] <= inValid;
      if (inFire) begin
        s1Zp <= zpD;
        s1Op <= opD;
      end
      // Stage 2 refills whenever it drains or is empty; a simultaneous
      // output transfer and refill keeps outValid high with new data.
      if (s1Advance) begin
        vldPipe[2] <= vldPipe[1];
        if (vldPipe[1]) begin
          N_ZP  <= ~&s1Zp;
          N_OP  <= ~&s1Op;
          zpSeg <= zpSegD;
          opSeg <= opSegD;
        end
      end
    end
  end

`ifdef P405S_ZOP_STICKY_EN
  logic outFire;
  assign outFire = outValid & outReady;

  // A set on a delivered result wins over a same-cycle clear.
  always_ff @(posedge CB) begin
    if (!resetN) begin
      stickyZP <= 1'b0;
      stickyOP <= 1'b0;
    end else begin
      if (outFire && !N_ZP)  stickyZP <= 1'b1;
      else if (stickyClr)    stickyZP <= 1'b0;
      if (outFire && !N_OP)  stickyOP <= 1'b1;
      else if (stickyClr)    stickyOP <= 1'b0;
    end
  end
`else
  // No sticky state in this build.
`endif

endmodule

// File: tb/tb_p405s_zero_one_predict_pipe.sv
// Directed bench for p405s_zero_one_predict_pipe: a 32-bit instance for
// hand-computed vectors, stall, and reset; a 64-bit instance for a
// back-to-back stream against an adder reference.
module tb_p405s_zero_one_predict_pipe;

  logic CB = 1'b0;
  always #5 CB = ~CB;

  logic resetN;

  logic [0:31] a32, b32;
  logic        cIn32, sub32, inValid32, inReady32, outValid32, outReady32;
  logic        nZp32, nOp32;
  logic [0:1]  zpSeg32, opSeg32;

  logic [0:63] a64, b64;
  logic        cIn64, sub64, inValid64, inReady64, outValid64, outReady64;
  logic        nZp64, nOp64;
  logic [0:3]  zpSeg64, opSeg64;

`ifdef P405S_ZOP_STICKY_EN
  logic stickyClr32, stickyZP32, stickyOP32;
  logic stickyClr64, stickyZP64, stickyOP64;
`endif

  p405s_zero_one_predict_pipe #(.WIDTH(32), .SEG_W(16)) dut32 (
    .CB(CB), .resetN(resetN), .aIn(a32), .bIn(b32), .cIn(cIn32),
    .subMode(sub32), .inValid(inValid32), .inReady(inReady32),
    .outValid(outValid32), .outReady(outReady32), .N_ZP(nZp32),
    .N_OP(nOp32), .zpSeg(zpSeg32), .opSeg(opSeg32)
`ifdef P405S_ZOP_STICKY_EN
    , .stickyClr(stickyClr32), .stickyZP(stickyZP32), .stickyOP(stickyOP32)
`endif
  );

  p405s_zero_one_predict_pipe #(.WIDTH(64), .SEG_W(16)) dut64 (
    .CB(CB), .resetN(resetN), .aIn(a64), .bIn(b64), .cIn(cIn64),
    .subMode(sub64), .inValid(inValid64), .inReady(inReady64),
    .outValid(outValid64), .outReady(outReady64), .N_ZP(nZp64),
    .N_OP(nOp64), .zpSeg(zpSeg64), .opSeg(opSeg64)
`ifdef P405S_ZOP_STICKY_EN
    , .stickyClr(stickyClr64), .stickyZP(stickyZP64), .stickyOP(stickyOP64)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CB);
    #1;
  endtask

  // {N_ZP, N_OP, zpSeg, opSeg} for the 32-bit instance
  function automatic logic [5:0] res32();
    return {nZp32, nOp32, zpSeg32, opSeg32};
  endfunction

  // Reference for the 64-bit instance: the full-width flags come from a
  // real adder; segment flags from the vector form of the predictors.
  function automatic logic [9:0] ref64(input logic [63:0] a, input logic [63:0] b,
                                       input logic c, input logic s);
    logic [63:0] eb, sum, t, o, g, zv, ov;
    logic [3:0]  zs, os;
    eb  = s ? ~b : b;
    sum = a + eb + {63'b0, c};
    t   = a ^ eb;
    o   = a | eb;
    g   = a & eb;
    zv  = ~(t ^ {o[62:0], c});
    ov  = t ^ {g[62:0], c};
    for (int j = 0; j < 4; j++) begin
      zs[j] = &zv[16*j +: 16];
      os[j] = &ov[16*j +: 16];
    end
    return {sum != 64'd0, sum != {64{1'b1}}, zs, os};
  endfunction

  // Single operand set through an otherwise idle 32-bit pipe.
  task automatic dirVec(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic s, input logic [5:0] exp);
    a32 = a; b32 = b; cIn32 = c; sub32 = s; inValid32 = 1'b1;
    chk({tag, ".rdy"}, inReady32, 1'b1);
    tick;
    inValid32 = 1'b0;
    chk({tag, ".v1"}, outValid32, 1'b0);
    tick;
    chk({tag, ".v2"}, outValid32, 1'b1);
    chk(tag, res32(), exp);
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] expQ[$];
    logic [9:0] e;
    logic [63:0] ra, rb;
    int acc, nRes;

    resetN = 1'b0;
    a32 = '0; b32 = '0; cIn32 = 1'b0; sub32 = 1'b0; inValid32 = 1'b0; outReady32 = 1'b1;
    a64 = '0; b64 = '0; cIn64 = 1'b0; sub64 = 1'b0; inValid64 = 1'b0; outReady64 = 1'b1;
`ifdef P405S_ZOP_STICKY_EN
    stickyClr32 = 1'b0; stickyClr64 = 1'b0;
`endif
    tick; tick;
    chk("rst.outValid", outValid32, 1'b0);
    chk("rst.res", res32(), 6'b110000);
    chk("rst.inReady", inReady32, 1'b0);
`ifdef P405S_ZOP_STICKY_EN
    chk("rst.sticky", {stickyZP32, stickyOP32}, 2'b00);
`endif
    resetN = 1'b1;
    #1;
    chk("rel.inReady", inReady32, 1'b1);

    // {N_ZP, N_OP, zpSeg[0:1], opSeg[0:1]}
    dirVec("zero",     32'h0,        32'h0,        1'b0, 1'b0, 6'b011100);
    dirVec("ones.c1",  32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, 6'b011110);
    dirVec("ones.c0",  32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 6'b101011);
    dirVec("sub.eq",   32'h12345678, 32'h12345678, 1'b1, 1'b1, 6'b011110);
    dirVec("sub.ne",   32'h12345679, 32'h12345678, 1'b1, 1'b1, 6'b111010);
    dirVec("add.1p2",  32'h00000001, 32'h00000002, 1'b0, 1'b0, 6'b111000);

`ifdef P405S_ZOP_STICKY_EN
    chk("sticky.set", {stickyZP32, stickyOP32}, 2'b11);
    stickyClr32 = 1'b1;
    tick;
    stickyClr32 = 1'b0;
    chk("sticky.clr", {stickyZP32, stickyOP32}, 2'b00);
`endif

    // Stall: downstream blocked, upstream offering every cycle.
    outReady32 = 1'b0;
    acc = 0;
    for (int n = 0; n < 5; n++) begin
      a32 = (acc == 0) ? 32'h0 : 32'hFFFFFFFF;
      b32 = 32'h0; cIn32 = 1'b0; sub32 = 1'b0; inValid32 = 1'b1;
      if (inReady32) acc++;
      tick;
    end
    chk("stall.accepted", acc, 2);
    chk("stall.inReady", inReady32, 1'b0);
    chk("stall.outValid", outValid32, 1'b1);
    chk("stall.res", res32(), 6'b011100);
    tick; tick;
    chk("stall.hold.v", outValid32, 1'b1);
    chk("stall.hold.res", res32(), 6'b011100);
    chk("stall.hold.rdy", inReady32, 1'b0);
    inValid32 = 1'b0;
    outReady32 = 1'b1;
    tick;
    chk("drain.v1", outValid32, 1'b1);
    chk("drain.res1", res32(), 6'b101011);
    tick;
    chk("drain.v2", outValid32, 1'b0);

    // Reset with both stages full.
    outReady32 = 1'b0;
    a32 = 32'h0; b32 = 32'h0; inValid32 = 1'b1;
    tick; tick;
    chk("full.outValid", outValid32, 1'b1);
`ifdef P405S_ZOP_STICKY_EN
    chk("full.sticky", {stickyZP32, stickyOP32}, 2'b11);
`endif
    resetN = 1'b0;
    tick;
    chk("frst.outValid", outValid32, 1'b0);
    chk("frst.res", res32(), 6'b110000);
    chk("frst.inReady", inReady32, 1'b0);
`ifdef P405S_ZOP_STICKY_EN
    chk("frst.sticky", {stickyZP32, stickyOP32}, 2'b00);
`endif
    resetN = 1'b1;
    inValid32 = 1'b0;
    outReady32 = 1'b1;
    tick;
    chk("frst.gone1", outValid32, 1'b0);
    tick;
    chk("frst.gone2", outValid32, 1'b0);

    // 64-bit back-to-back stream.
    nRes = 0;
    for (int t = 0; t < 102; t++) begin
      if (t < 100) begin
        ra = {$urandom(), $urandom()};
        rb = {$urandom(), $urandom()};
        cIn64 = 1'($urandom_range(1));
        sub64 = 1'($urandom_range(1));
        if (t % 8 == 0) begin rb = ra; sub64 = 1'b1; cIn64 = 1'b1; end
        if (t % 8 == 4) begin rb = ~ra; sub64 = 1'b0; cIn64 = 1'b0; end
        a64 = ra; b64 = rb; inValid64 = 1'b1;
        expQ.push_back(ref64(ra, rb, cIn64, sub64));
        chk("s64.rdy", inReady64, 1'b1);
      end else begin
        inValid64 = 1'b0;
      end
      tick;
      chk("s64.valid", outValid64, (t >= 1 && t <= 100));
      if (outValid64) begin
        if (expQ.size() == 0) begin
          chk("s64.extra", 1'b1, 1'b0);
        end else begin
          e = expQ.pop_front();
          chk("s64.res", {nZp64, nOp64, zpSeg64, opSeg64}, e);
          nRes++;
        end
      end
    end
    chk("s64.count", nRes, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
